fp_mul_seq_ctrl: RTL and testbench
==================================

FP_MUL_SEQ_CTRL -- requirements
Module: fp_mul_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports a and b, input, 32 each, IEEE-754 single operands, sampled on accept.
REQ-004 SHALL have port in_valid, input, 1, operand pair offered.
REQ-005 SHALL have port in_ready, output, 1, high only in IDLE.
REQ-006 SHALL have port out_valid, output, 1, result held valid.
REQ-007 SHALL have port out_ready, input, 1, consumer takes result.
REQ-008 SHALL have port result, output, 32, product, stable while out_valid.
REQ-009 SHALL have port flags, output, 4, {nan, inf, ovf, unf}, stable while out_valid.

Function
REQ-010 SHALL implement FSM IDLE, MUL, NORM, DONE.
REQ-011 SHALL accept when in_valid && in_ready in IDLE (cycle T): latch operands, classify, go MUL; else stay IDLE.
REQ-012 SHALL treat E=0 inputs as signed zero (denormals flushed), E=255/F=0 as inf, E=255/F!=0 as NaN.
REQ-013 SHALL bypass MUL/NORM for any zero/inf/NaN operand, going IDLE->DONE, out_valid at T+1.
REQ-014 Special results SHALL be: NaN operand or inf*0 -> 0x7FC00000, flags.nan=1; inf*finite/inf -> signed inf, flags.inf=1; zero*finite -> signed zero.
REQ-015 Sign SHALL be a[31]^b[31] for all non-NaN results.
REQ-016 MUL SHALL run 24 cycles, one shift-add of the 24-bit multiplicand per multiplier bit (LSB first) into a 48-bit product register via an iteration counter 0..23.
REQ-017 NORM SHALL take 1 cycle: if product[47]=1 take bits [46:24] and exponent+1, else bits [45:23]; exponent = Ea+Eb-127 computed in 10-bit signed arithmetic.
REQ-018 Exponent >=255 after normalise/round SHALL give signed inf, flags.ovf=1 and flags.inf=1; exponent <=0 SHALL give signed zero, flags.unf=1.
REQ-019 Normal-path out_valid SHALL assert at T+26 (24 MUL + 1 NORM + entry).
REQ-020 DONE SHALL hold out_valid, result, flags until out_ready=1, then go IDLE next cycle; no accept in the same cycle as release.
REQ-021 in_valid SHALL be ignored in MUL, NORM, DONE.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, in_ready=1 after release, out_valid=0, result=0, flags=0, counter=0, product=0.
REQ-023 Reset mid-MUL or in DONE SHALL discard the operation without output.

Configuration
REQ-024 With FPMUL_RNE_EN defined, NORM SHALL round to nearest-even using guard and sticky (OR of remaining bits), incl. mantissa carry-out into exponent.
REQ-025 Without FPMUL_RNE_EN, NORM SHALL truncate; latency identical in both builds.

Structure
REQ-026 Package fpmul_pkg SHALL hold state enum, BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, MUL_ITERS=24, flag bit indices.
REQ-027 Sub-module fp_classify (zero/inf/nan per operand) SHALL be instantiated twice; datapath otherwise inline.

Verification
REQ-028 a=0x3FC00000, b=0x40000000, out_ready=1 -> result 0x40400000, flags 0, out_valid at T+26.
REQ-029 a=0x7F800000, b=0x00000000 -> result 0x7FC00000, flags.nan=1, out_valid at T+1.
REQ-030 a=b=0x7F000000 -> result 0x7F800000, flags.ovf=1, inf=1; a=b=0x00800000 -> 0x00000000, unf=1.
REQ-031 a=0x3FC00000, b=0x3F800001 -> 0x3FC00002 with FPMUL_RNE_EN, 0x3FC00001 without.
REQ-032 Hold out_ready=0 for 5 cycles after out_valid -> result/flags stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE next cycle.
REQ-033 Assert rst_n=0 at MUL iteration 10 -> out_valid stays 0, in_ready=1 after release, next operation correct.

Source files
------------

// File: rtl/fpmul_pkg.sv
// Shared definitions for the sequential single-precision multiplier.
// Holds the controller state encoding, the IEEE-754 exponent constants,
// the canonical quiet NaN, the shift-add iteration count and the bit
// positions inside the 4-bit flags output ({nan, inf, ovf, unf}).
package fpmul_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_NORM = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic signed [9:0] BIAS    = 10'sd127;
  localparam logic signed [9:0] EXP_MAX = 10'sd255;
  localparam logic [31:0]       QNAN    = 32'h7FC0_0000;
  localparam int unsigned       MUL_ITERS = 24;

  localparam int unsigned FLAG_NAN = 3;
  localparam int unsigned FLAG_INF = 2;
  localparam int unsigned FLAG_OVF = 1;
  localparam int unsigned FLAG_UNF = 0;

endpackage

// File: rtl/fp_classify.sv
// Classifies one IEEE-754 single operand.
// Ports:
//   i_op   : 32-bit operand
//   o_zero : exponent field zero (denormals are treated as signed zero)
//   o_inf  : exponent all ones, fraction zero
//   o_nan  : exponent all ones, fraction non-zero
module fp_classify (
  input  logic [31:0] i_op,
  output logic        o_zero,
  output logic        o_inf,
  output logic        o_nan
);

  logic w_exp_ones;
  logic w_frac_zero;

  assign w_exp_ones  = &i_op[30:23];
  assign w_frac_zero = ~|i_op[22:0];
  assign o_zero      = ~|i_op[30:23];
  assign o_inf       = w_exp_ones & w_frac_zero;
  assign o_nan       = w_exp_ones & ~w_frac_zero;

endmodule

// File: rtl/fp_mul_seq_ctrl.sv
// Sequential IEEE-754 single-precision multiplier with valid/ready handshake.
// An operand pair is taken in IDLE; zero/inf/NaN operands bypass straight to
// DONE, otherwise a 24-cycle shift-add multiply and a 1-cycle normalise run
// before the result is presented. DONE holds result and flags until the
// consumer takes them.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   a, b                : operands, sampled on accept
//   in_valid / in_ready : input handshake (in_ready high only in IDLE)
//   out_valid/out_ready : output handshake
//   result              : product
//   flags               : {nan, inf, ovf, unf}
// Configuration:
//   FPMUL_RNE_EN        : when defined, normalise rounds to nearest-even;
//                         otherwise the mantissa is truncated. Latency is the
//                         same in both builds.
module fp_mul_seq_ctrl
  import fpmul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  state_t            r_state;
  logic [23:0]       r_mcand;
  logic [23:0]       r_mplier;
  logic [47:0]       r_prod;
  logic [4:0]        r_cnt;
  logic signed [9:0] r_exp;
  logic              r_sign;
  logic [31:0]       r_result;
  logic [3:0]        r_flags;

  logic w_a_zero, w_a_inf, w_a_nan;
  logic w_b_zero, w_b_inf, w_b_nan;
  logic w_sign;
  logic w_special;
  logic [31:0] w_spec_result;
  logic [3:0]  w_spec_flags;

  logic [22:0]       w_mant;
  logic              w_rnd_up;
  logic [23:0]       w_mant_r;
  logic signed [9:0] w_exp_n;
  logic signed [9:0] w_exp_f;
  logic [31:0]       w_norm_result;
  logic [3:0]        w_norm_flags;

  fp_classify u_class_a (.i_op(a), .o_zero(w_a_zero), .o_inf(w_a_inf), .o_nan(w_a_nan));
  fp_classify u_class_b (.i_op(b), .o_zero(w_b_zero), .o_inf(w_b_inf), .o_nan(w_b_nan));

  assign w_sign    = a[31] ^ b[31];
  assign w_special = w_a_zero | w_a_inf | w_a_nan | w_b_zero | w_b_inf | w_b_nan;

  always_comb begin
    w_spec_result = {w_sign, 31'b0};
    w_spec_flags  = '0;
    if (w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero)) begin
      w_spec_result          = QNAN;
      w_spec_flags[FLAG_NAN] = 1'b1;
    end else if (w_a_inf | w_b_inf) begin
      w_spec_result          = {w_sign, 8'hFF, 23'b0};
      w_spec_flags[FLAG_INF] = 1'b1;
    end
  end

  // Both mantissas carry the hidden 1, so the product is in [1,4) and
  // bit 47 tells whether one extra normalising shift is needed.
  always_comb begin
    if (r_prod[47]) begin
      w_mant  = r_prod[46:24];
      w_exp_n = r_exp + 10'sd1;
    end else begin
      w_mant  = r_prod[45:23];
      w_exp_n = r_exp;
    end
  end

`ifdef FPMUL_RNE_EN
  logic w_guard;
  logic w_sticky;
  assign w_guard  = r_prod[47] ? r_prod[23]    : r_prod[22];
  assign w_sticky = r_prod[47] ? |r_prod[22:0] : |r_prod[21:0];
  assign w_rnd_up = w_guard & (w_sticky | w_mant[0]);
`else
  assign w_rnd_up = 1'b0;
`endif

  // A rounding carry out of the mantissa leaves a zero fraction and bumps
  // the exponent.
  assign w_mant_r = {1'b0, w_mant} + {23'b0, w_rnd_up};
  assign w_exp_f  = w_mant_r[23] ? (w_exp_n + 10'sd1) : w_exp_n;

  always_comb begin
    w_norm_result = {r_sign, w_exp_f[7:0], w_mant_r[22:0]};
    w_norm_flags  = '0;
    if (w_exp_f >= EXP_MAX) begin
      w_norm_result          = {r_sign, 8'hFF, 23'b0};
      w_norm_flags[FLAG_OVF] = 1'b1;
      w_norm_flags[FLAG_INF] = 1'b1;
    end else if (w_exp_f <= 10'sd0) begin
      w_norm_result          = {r_sign, 31'b0};
      w_norm_flags[FLAG_UNF] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_exp    <= '0;
      r_sign   <= 1'b0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign   <= w_sign;
            r_mcand  <= {1'b1, a[22:0]};
            r_mplier <= {1'b1, b[22:0]};
            r_exp    <= $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - BIAS;
            r_prod   <= '0;
            r_cnt    <= '0;
            if (w_special) begin
              r_result <= w_spec_result;
              r_flags  <= w_spec_flags;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (r_mplier[r_cnt]) begin
            r_prod <= r_prod + ({24'b0, r_mcand} << r_cnt);
          end
          if (r_cnt == 5'(MUL_ITERS - 1)) begin
            r_cnt   <= '0;
            r_state <= S_NORM;
          end else begin
            r_cnt   <= r_cnt + 5'd1;
          end
        end
        S_NORM: begin
          r_result <= w_norm_result;
          r_flags  <= w_norm_flags;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: tb/tb_fp_mul_seq_ctrl.sv
// Directed self-checking bench for fp_mul_seq_ctrl.
module tb_fp_mul_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  fp_mul_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offers one pair, waits (bounded) for out_valid, captures, then releases.
  // lat = 1 means out_valid in the cycle right after the accept cycle.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_op,
                        output logic [31:0] res, output logic [3:0] fl, output int lat);
    a = ta; b = tb_op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result; fl = flags;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 00000000", result); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags got %h want 0", flags); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_normal();
    logic [31:0] vin_a [3] = '{32'h3FC00000, 32'hC0000000, 32'h3FC00000};
    logic [31:0] vin_b [3] = '{32'h40000000, 32'h40400000, 32'h3FC00000};
    logic [31:0] vexp  [3] = '{32'h40400000, 32'hC0C00000, 32'h40100000};
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      run_op(vin_a[i], vin_b[i], res, fl, lat);
      checks++; if (res !== vexp[i]) begin errors++; $display("FAIL normal_result[%0d] got %h want %h", i, res, vexp[i]); end
      checks++; if (fl !== 4'h0) begin errors++; $display("FAIL normal_flags[%0d] got %h want 0", i, fl); end
      checks++; if (lat !== 26) begin errors++; $display("FAIL normal_latency[%0d] got %0d want 26", i, lat); end
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
        $display("FAIL normal_release[%0d] got in_ready=%b out_valid=%b want 1/0", i, in_ready, out_valid); end
    end
  endtask

  task automatic test_special();
    logic [31:0] vin_a [5] = '{32'h7F800000, 32'hFF800000, 32'h80000000, 32'h7F800001, 32'h00000001};
    logic [31:0] vin_b [5] = '{32'h00000000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    logic [31:0] vexp  [5] = '{32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h7FC00000, 32'h00000000};
    logic [3:0]  vfl   [5] = '{4'b1000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_op(vin_a[i], vin_b[i], res, fl, lat);
      checks++; if (res !== vexp[i]) begin errors++; $display("FAIL special_result[%0d] got %h want %h", i, res, vexp[i]); end
      checks++; if (fl !== vfl[i]) begin errors++; $display("FAIL special_flags[%0d] got %b want %b", i, fl, vfl[i]); end
      checks++; if (lat !== 1) begin errors++; $display("FAIL special_latency[%0d] got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_range();
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
    run_op(32'h7F000000, 32'h7F000000, res, fl, lat);
    checks++; if (res !== 32'h7F800000) begin errors++; $display("FAIL ovf_result got %h want 7f800000", res); end
    checks++; if (fl !== 4'b0110) begin errors++; $display("FAIL ovf_flags got %b want 0110", fl); end
    checks++; if (lat !== 26) begin errors++; $display("FAIL ovf_latency got %0d want 26", lat); end
    run_op(32'h00800000, 32'h00800000, res, fl, lat);
    checks++; if (res !== 32'h00000000) begin errors++; $display("FAIL unf_result got %h want 00000000", res); end
    checks++; if (fl !== 4'b0001) begin errors++; $display("FAIL unf_flags got %b want 0001", fl); end
  endtask

  task automatic test_rounding();
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
    logic [31:0] want;
`ifdef FPMUL_RNE_EN
    want = 32'h3FC00002;
`else
    want = 32'h3FC00001;
`endif
    run_op(32'h3FC00000, 32'h3F800001, res, fl, lat);
    checks++; if (res !== want) begin errors++; $display("FAIL round_result got %h want %h", res, want); end
    checks++; if (lat !== 26) begin errors++; $display("FAIL round_latency got %0d want 26", lat); end
  endtask

  task automatic test_hold();
    int wait_cyc = 0;
    a = 32'h3FC00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && wait_cyc < 60) begin @(posedge clk); #1; wait_cyc++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_wait got out_valid=%b want 1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      a = 32'h7F800000; b = 32'h00000000; in_valid = (i % 2 == 0);
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++;
        $display("FAIL hold_hs[%0d] got out_valid=%b in_ready=%b want 1/0", i, out_valid, in_ready); end
      checks++; if (result !== 32'h40400000 || flags !== 4'h0) begin errors++;
        $display("FAIL hold_data[%0d] got %h/%h want 40400000/0", i, result, flags); end
    end
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL hold_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
    logic        seen = 1'b0;
    a = 32'h3FC00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL midreset_state got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_output got out_valid seen=%b want 0", seen); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
    run_op(32'h3FC00000, 32'h40000000, res, fl, lat);
    checks++; if (res !== 32'h40400000 || lat !== 26) begin errors++;
      $display("FAIL midreset_next got %h lat %0d want 40400000 lat 26", res, lat); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_rounding();
    test_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
